instr_encoder: RTL and testbench

- Inverse of the instruction decoder: accepts field-level instruction descriptions (cond, op, funct, Rn, Rd, Src2/imm24) over a valid/ready stream.
- Packs each description into a 32-bit ARM-subset machine word and buffers it in a FIFO.
- Writes the buffered words sequentially into instruction memory through a write port with stall.
- Used by bench and boot-loader logic to build programs for the single-cycle core.

---
 rtl/instr_encoder.sv | 155 +++++++++++++++
 tb/tb_instr_encoder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Field-level instruction encoder with a FIFO feeding an instruction-memory write port.
// Optional BRANCH_ABS_EN: branch imm24 is an absolute target byte address.
module instr_encoder #(
    parameter int DEPTH = 4,
    parameter int ADDR_W = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [3:0]        cond,
    input  logic [1:0]        op,
    input  logic [5:0]        funct,
    input  logic [3:0]        rn,
    input  logic [3:0]        rd,
    input  logic [11:0]       src2,
    input  logic [23:0]       imm24,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wd,
    input  logic              imem_stall,
    output logic [15:0]       count,
    output logic              err,
    output logic              done
);

    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state;
    logic              last_seen;
    logic [31:0]       mem [DEPTH];
    logic [PW-1:0]     wptr;
    logic [PW-1:0]     rptr;
    logic [PW:0]       used;
    logic [PW:0]       used_nx;
    logic [ADDR_W-1:0] addr;
    logic              full;
    logic              empty;
    logic              hs;
    logic              push;
    logic              pop;
    logic              last_nx;
    logic              legal;
    logic [31:0]       word;
    logic [23:0]       br_off;

`ifdef BRANCH_ABS_EN
    logic [ADDR_W-1:0] enq_addr;

    // Offset is relative to the word's own address plus the 8-byte pipeline lead.
    assign br_off = 24'((26'(imm24) - 26'(enq_addr) - 26'd8) >> 2);
`else
    assign br_off = imm24;
`endif

    always_comb begin
        word  = {cond, op, funct, rn, rd, src2};
        legal = 1'b1;
        case (op)
            2'b00: legal = funct[4:1] inside {4'b0100, 4'b0101, 4'b0010,
                                              4'b0000, 4'b1100};
            2'b10: word = {cond, 2'b10, funct[5:4], br_off};
            2'b11: legal = 1'b0;
            default: ;
        endcase
`ifdef BRANCH_ABS_EN
        if (op == 2'b10 && imm24[1:0] != 2'b00) begin
            legal = 1'b0;
        end
`endif
    end

    assign full      = (used == (PW+1)'(DEPTH));
    assign empty     = (used == '0);
    assign in_ready  = !full && state != S_DONE;
    assign hs        = in_valid && in_ready;
    assign push      = hs && legal;
    assign imem_we   = !empty && state != S_DONE;
    assign pop       = imem_we && !imem_stall;
    assign imem_wd   = mem[rptr];
    assign imem_addr = addr;
    assign used_nx   = used + (PW+1)'(push) - (PW+1)'(pop);
    assign last_nx   = last_seen || (hs && in_last);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= word;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            last_seen <= 1'b0;
            wptr      <= '0;
            rptr      <= '0;
            used      <= '0;
            addr      <= BASE_ADDR;
            count     <= '0;
            err       <= 1'b0;
            done      <= 1'b0;
`ifdef BRANCH_ABS_EN
            enq_addr  <= BASE_ADDR;
`endif
        end else begin
            used <= used_nx;
            if (push) begin
                wptr <= wptr + 1'b1;
`ifdef BRANCH_ABS_EN
                enq_addr <= enq_addr + ADDR_W'(4);
`endif
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
                addr <= addr + ADDR_W'(4);
                if (count != 16'hFFFF) begin
                    count <= count + 16'd1;
                end
            end
            if (hs && !legal) begin
                err <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (hs) begin
                        last_seen <= last_nx;
                        if (last_nx && used_nx == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    last_seen <= last_nx;
                    if (last_nx && used_nx == '0) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder (DEPTH=4, ADDR_W=32, BASE_ADDR=0).
// Compile with +define+BRANCH_ABS_EN to exercise absolute branch targets.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [11:0] src2;
    logic [23:0] imm24;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wd;
    logic        imem_stall;
    logic [15:0] count;
    logic        err;
    logic        done;

    int tests = 0;
    int fails = 0;

    instr_encoder #(.DEPTH(4), .ADDR_W(32), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .cond(cond), .op(op), .funct(funct), .rn(rn),
        .rd(rd), .src2(src2), .imm24(imm24), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wd(imem_wd), .imem_stall(imem_stall),
        .count(count), .err(err), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic set_desc(input logic [1:0] o, input logic [5:0] f,
                            input logic [3:0] n, input logic [3:0] d,
                            input logic [11:0] s, input logic [23:0] i);
        in_valid = 1'b1;
        cond     = 4'hE;
        op       = o;
        funct    = f;
        rn       = n;
        rd       = d;
        src2     = s;
        imm24    = i;
    endtask

    task automatic set_add(input logic [11:0] s);
        set_desc(2'b00, 6'b101000, 4'd2, 4'd1, s, 24'h0);
    endtask

    initial begin
        reset      = 1'b0;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        imem_stall = 1'b0;
        set_desc(2'b00, 6'b0, 4'd0, 4'd0, 12'h0, 24'h0);
        in_valid = 1'b0;
        tick();
        tick();
        chk("rst_we", {31'b0, imem_we}, 32'd0);
        chk("rst_count", {16'b0, count}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_ready", {31'b0, in_ready}, 32'd1);
        reset = 1'b1;

        set_add(12'h005);
        tick();
        in_valid = 1'b0;
        chk("add_we", {31'b0, imem_we}, 32'd1);
        chk("add_addr", imem_addr, 32'h0);
        chk("add_wd", imem_wd, 32'hE2821005);
        tick();
        chk("add_count", {16'b0, count}, 32'd1);
        chk("add_we_off", {31'b0, imem_we}, 32'd0);

`ifndef BRANCH_ABS_EN
        do_reset();
        set_desc(2'b01, 6'b011001, 4'd0, 4'd3, 12'h008, 24'h0);
        tick();
        set_desc(2'b10, 6'b100000, 4'd0, 4'd0, 12'h0, 24'hFFFFFE);
        chk("ldr_wd", imem_wd, 32'hE5903008);
        chk("ldr_addr", imem_addr, 32'h0);
        tick();
        in_valid = 1'b0;
        chk("b_we", {31'b0, imem_we}, 32'd1);
        chk("b_wd", imem_wd, 32'hEAFFFFFE);
        chk("b_addr", imem_addr, 32'h4);
        tick();
        chk("lb_count", {16'b0, count}, 32'd2);
`endif

        do_reset();
        set_desc(2'b11, 6'b0, 4'd0, 4'd0, 12'h0, 24'h0);
        tick();
        chk("op11_err", {31'b0, err}, 32'd1);
        chk("op11_we", {31'b0, imem_we}, 32'd0);
        set_add(12'h005);
        tick();
        in_valid = 1'b0;
        chk("op11_next_addr", imem_addr, 32'h0);
        chk("op11_next_wd", imem_wd, 32'hE2821005);
        tick();
        chk("op11_count", {16'b0, count}, 32'd1);

        do_reset();
        set_desc(2'b00, 6'b000010, 4'd2, 4'd1, 12'h0, 24'h0);
        tick();
        in_valid = 1'b0;
        chk("badfunct_err", {31'b0, err}, 32'd1);
        chk("badfunct_we", {31'b0, imem_we}, 32'd0);

        do_reset();
        imem_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_add(12'(i));
            chk("stall_ready", {31'b0, in_ready}, 32'd1);
            tick();
        end
        set_add(12'h004);
        chk("full_ready", {31'b0, in_ready}, 32'd0);
        chk("stall_wd", imem_wd, 32'hE2821000);
        tick();
        in_valid = 1'b0;
        chk("stall_hold_wd", imem_wd, 32'hE2821000);
        chk("stall_hold_addr", imem_addr, 32'h0);
        imem_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("drain_we", {31'b0, imem_we}, 32'd1);
            chk("drain_addr", imem_addr, 32'(4 * i));
            chk("drain_wd", imem_wd, 32'hE2821000 + 32'(i));
            tick();
        end
        chk("drain_ready", {31'b0, in_ready}, 32'd1);
        chk("drain_count", {16'b0, count}, 32'd4);

        do_reset();
        set_add(12'h001);
        tick();
        set_add(12'h002);
        tick();
        set_add(12'h003);
        in_last = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("last_addr", imem_addr, 32'h8);
        chk("last_done_pre", {31'b0, done}, 32'd0);
        tick();
        chk("done", {31'b0, done}, 32'd1);
        chk("done_ready", {31'b0, in_ready}, 32'd0);
        chk("done_we", {31'b0, imem_we}, 32'd0);
        chk("done_count", {16'b0, count}, 32'd3);
        do_reset();
        chk("rst2_done", {31'b0, done}, 32'd0);
        chk("rst2_count", {16'b0, count}, 32'd0);
        set_add(12'h007);
        tick();
        in_valid = 1'b0;
        chk("rst2_addr", imem_addr, 32'h0);
        chk("rst2_wd", imem_wd, 32'hE2821007);

        do_reset();
        set_desc(2'b11, 6'b0, 4'd0, 4'd0, 12'h0, 24'h0);
        in_last = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("droplast_done", {31'b0, done}, 32'd1);
        chk("droplast_err", {31'b0, err}, 32'd1);

`ifdef BRANCH_ABS_EN
        do_reset();
        set_add(12'h000);
        tick();
        set_add(12'h001);
        tick();
        set_desc(2'b10, 6'b100000, 4'd0, 4'd0, 12'h0, 24'h000000);
        tick();
        in_valid = 1'b0;
        chk("abs_addr", imem_addr, 32'h8);
        chk("abs_wd", imem_wd, 32'hEAFFFFFC);
        tick();
        set_desc(2'b10, 6'b100000, 4'd0, 4'd0, 12'h0, 24'h000002);
        tick();
        in_valid = 1'b0;
        chk("abs_misalign_err", {31'b0, err}, 32'd1);
        chk("abs_misalign_we", {31'b0, imem_we}, 32'd0);
        chk("abs_count", {16'b0, count}, 32'd3);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
